ddr_pixel_unpacker: RTL and testbench

- Downstream of the DDR memory handler, in the ui_clk domain.
- Issues one-at-a-time word reads (rd_en/rd_addr) to the handler, buffers returned 128-bit words in a small FIFO, and unpacks 5 RGB888 pixels per word.
- Presents pixels as a valid/ready stream to the video/VGA path.
- Drops padding slots in the last word of each frame and flags frame/sequence boundaries.

---
 rtl/ddr_video_pkg.sv | 18 +
 rtl/word_fifo.sv | 52 +++++
 rtl/ddr_pixel_unpacker.sv | 203 ++++++++++++++++++++
 tb/tb_ddr_pixel_unpacker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_video_pkg.sv
// rtl/ddr_video_pkg.sv - shared widths, defaults, pixel type and request states for DDR video readback
package ddr_video_pkg;
  localparam int PIXELS_PER_WORD      = 5;
  localparam int PIXEL_BITS           = 24;
  localparam int WORD_BITS            = 128;
  localparam int DEF_MAX_ADDRESS      = 39322;
  localparam int DEF_NUMBER_OF_PIXELS = 196608;
  localparam int DEF_NUMBER_OF_FRAMES = 226;

  typedef logic [PIXEL_BITS-1:0] rgb888_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} req_state_t;

  // Slot 4 lands on [119:96]; the top byte of a word never carries pixel data.
  function automatic rgb888_t word_slot(input logic [WORD_BITS-1:0] word, input logic [2:0] slot);
    return word[PIXEL_BITS*slot +: PIXEL_BITS];
  endfunction
endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - DEPTH x WIDTH synchronous word buffer with push/pop/full/empty/count
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/ddr_pixel_unpacker.sv
// rtl/ddr_pixel_unpacker.sv - single-outstanding DDR word reader and 5-pixel-per-word RGB888 stream unpacker
// Optional LOOP_PLAYBACK_EN: wrap to address 0 after the last frame instead of parking in DONE.
module ddr_pixel_unpacker
  import ddr_video_pkg::*;
#(
  parameter int MAX_ADDRESS      = DEF_MAX_ADDRESS,
  parameter int NUMBER_OF_PIXELS = DEF_NUMBER_OF_PIXELS,
  parameter int NUMBER_OF_FRAMES = DEF_NUMBER_OF_FRAMES,
  parameter int FIFO_DEPTH       = 4,
  parameter int ADDR_WIDTH       = 24
) (
  input  logic                  clk,
  input  logic                  cpu_resetn,
  input  logic                  enable,
  input  logic                  end_of_write,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic                  busy_read,
  input  logic                  ddr_read_ready,
  input  logic [WORD_BITS-1:0]  rd_data_in,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output rgb888_t               pix_data,
  output logic                  pix_sof,
  output logic                  pix_eof,
  output logic                  seq_done
);
  localparam int WCW = (MAX_ADDRESS > 1) ? $clog2(MAX_ADDRESS) : 1;
  localparam int PCW = (NUMBER_OF_PIXELS > 1) ? $clog2(NUMBER_OF_PIXELS) : 1;
  localparam int FCW = (NUMBER_OF_FRAMES > 1) ? $clog2(NUMBER_OF_FRAMES) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  req_state_t            state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [FCW-1:0]        frame_cnt_q, frame_cnt_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [WORD_BITS-1:0]  fifo_dout;

  logic [WORD_BITS-1:0]  cur_word_q, cur_word_d, src_word;
  logic [2:0]            slot_q, slot_d, src_slot;
  logic                  have_word_q, have_word_d;
  logic                  pix_valid_q, pix_valid_d;
  rgb888_t               pix_data_q, pix_data_d;
  logic                  pix_sof_q, pix_sof_d, pix_eof_q, pix_eof_d;
  logic                  pix_last_frame_q, pix_last_frame_d;
  logic [PCW-1:0]        pix_cnt_q, pix_cnt_d;
  logic [FCW-1:0]        out_frame_q, out_frame_d;
  logic                  seq_done_q, seq_done_d;
  logic                  at_eof, at_last_frame;

  word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_BITS), .CW(CW)) u_fifo (
    .clk  (clk),
    .rst_n(cpu_resetn),
    .push (fifo_push),
    .din  (rd_data_in),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    fifo_push   = 1'b0;
    case (state_q)
      // Nothing is in flight while IDLE, so any free slot is enough to reserve room.
      IDLE: if (enable && end_of_write && (fifo_count < CW'(FIFO_DEPTH))) state_d = REQ;
      REQ:  if (busy_read) state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (ddr_read_ready) begin
          fifo_push = 1'b1;
          state_d   = IDLE;
          if (word_cnt_q == WCW'(MAX_ADDRESS - 1)) begin
            word_cnt_d = '0;
            if (frame_cnt_q == FCW'(NUMBER_OF_FRAMES - 1)) begin
              frame_cnt_d = '0;
              addr_d      = '0;
`ifdef LOOP_PLAYBACK_EN
              state_d     = IDLE;
`else
              state_d     = DONE;
`endif
            end else begin
              frame_cnt_d = frame_cnt_q + FCW'(1);
              addr_d      = addr_q + ADDR_WIDTH'(1);
            end
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
            addr_d     = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (!enable) begin
          state_d     = IDLE;
          addr_d      = '0;
          word_cnt_d  = '0;
          frame_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_en_d = (state_d == REQ);
  end

  always_comb begin
    cur_word_d       = cur_word_q;
    slot_d           = slot_q;
    have_word_d      = have_word_q;
    pix_valid_d      = pix_valid_q;
    pix_data_d       = pix_data_q;
    pix_sof_d        = pix_sof_q;
    pix_eof_d        = pix_eof_q;
    pix_last_frame_d = pix_last_frame_q;
    pix_cnt_d        = pix_cnt_q;
    out_frame_d      = out_frame_q;
    fifo_pop         = 1'b0;
    src_word         = cur_word_q;
    src_slot         = slot_q;
    at_eof           = (pix_cnt_q == PCW'(NUMBER_OF_PIXELS - 1));
    at_last_frame    = (out_frame_q == FCW'(NUMBER_OF_FRAMES - 1));
    seq_done_d       = pix_valid_q && pix_ready && pix_eof_q && pix_last_frame_q;
    if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;
    // An exhausted word is refilled straight from the FIFO head so slot 0 loads in the pop cycle.
    if ((!pix_valid_q || pix_ready) && (have_word_q || !fifo_empty)) begin
      if (!have_word_q) begin
        fifo_pop = 1'b1;
        src_word = fifo_dout;
        src_slot = 3'd0;
      end
      pix_valid_d      = 1'b1;
      pix_data_d       = word_slot(src_word, src_slot);
      pix_sof_d        = (pix_cnt_q == '0);
      pix_eof_d        = at_eof;
      pix_last_frame_d = at_last_frame;
      cur_word_d       = src_word;
      slot_d           = src_slot + 3'd1;
      have_word_d      = (src_slot != 3'(PIXELS_PER_WORD - 1)) && !at_eof;
      if (at_eof) begin
        pix_cnt_d   = '0;
        out_frame_d = at_last_frame ? '0 : out_frame_q + FCW'(1);
      end else begin
        pix_cnt_d   = pix_cnt_q + PCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q          <= IDLE;
      rd_en_q          <= 1'b0;
      addr_q           <= '0;
      word_cnt_q       <= '0;
      frame_cnt_q      <= '0;
      cur_word_q       <= '0;
      slot_q           <= '0;
      have_word_q      <= 1'b0;
      pix_valid_q      <= 1'b0;
      pix_data_q       <= '0;
      pix_sof_q        <= 1'b0;
      pix_eof_q        <= 1'b0;
      pix_last_frame_q <= 1'b0;
      pix_cnt_q        <= '0;
      out_frame_q      <= '0;
      seq_done_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_en_q          <= rd_en_d;
      addr_q           <= addr_d;
      word_cnt_q       <= word_cnt_d;
      frame_cnt_q      <= frame_cnt_d;
      cur_word_q       <= cur_word_d;
      slot_q           <= slot_d;
      have_word_q      <= have_word_d;
      pix_valid_q      <= pix_valid_d;
      pix_data_q       <= pix_data_d;
      pix_sof_q        <= pix_sof_d;
      pix_eof_q        <= pix_eof_d;
      pix_last_frame_q <= pix_last_frame_d;
      pix_cnt_q        <= pix_cnt_d;
      out_frame_q      <= out_frame_d;
      seq_done_q       <= seq_done_d;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!cpu_resetn) !(fifo_push && fifo_full));

  assign rd_en_out   = rd_en_q;
  assign rd_addr_out = addr_q;
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eof     = pix_eof_q;
  assign seq_done    = seq_done_q;
endmodule

// File: tb/tb_ddr_pixel_unpacker.sv
// tb/tb_ddr_pixel_unpacker.sv - directed bench with handler model and pixel-stream reference model
module tb_ddr_pixel_unpacker;
  localparam int MAXA = 3, NP = 13, NF = 2, DEPTH = 4, AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_resetn, enable, end_of_write, busy_read, ddr_read_ready, pix_ready;
  logic [127:0]  rd_data_in;
  logic          rd_en_out, pix_valid, pix_sof, pix_eof, seq_done;
  logic [AW-1:0] rd_addr_out;
  logic [23:0]   pix_data;

  ddr_pixel_unpacker #(
    .MAX_ADDRESS(MAXA), .NUMBER_OF_PIXELS(NP), .NUMBER_OF_FRAMES(NF),
    .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .cpu_resetn(cpu_resetn), .enable(enable), .end_of_write(end_of_write),
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .busy_read(busy_read),
    .ddr_read_ready(ddr_read_ready), .rd_data_in(rd_data_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eof(pix_eof), .seq_done(seq_done)
  );

  int n_total = 0, n_pass = 0;
  int busy_delay = 0, lat = 2, req_idx = 0, req_count = 0, acc_count = 0, seq_pulses = 0, base = 0;
  bit in_wait = 0;
  logic [23:0] acc_data[$];
  bit acc_sof[$], acc_eof[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Memory image: slot k of word a holds a*5+k+1; the unused top byte carries junk.
  function automatic logic [127:0] make_word(input int a);
    logic [127:0] w;
    w = '0;
    w[127:120] = 8'hA5;
    for (int k = 0; k < 5; k++) w[24*k +: 24] = 24'(a*5 + k + 1);
    return w;
  endfunction

  function automatic int exp_frame(input int n); return (n / NP) % NF; endfunction
  function automatic int exp_pix(input int n);
    int p;
    p = n % NP;
    return (exp_frame(n)*MAXA + p/5)*5 + p%5 + 1;
  endfunction
  function automatic int word_idx(input int n); return (n / NP)*MAXA + (n % NP)/5; endfunction

  // Handler model: busy after busy_delay cycles, data lat cycles later.
  initial begin
    busy_read = 0; ddr_read_ready = 0; rd_data_in = '0;
    forever begin
      @(negedge clk);
      if (cpu_resetn && rd_en_out) begin : serve
        logic [23:0] a;
        bit abort;
        a = rd_addr_out;
        abort = 0;
        chk("req_addr", a, req_idx % (MAXA*NF));
        req_idx++;
        req_count++;
        for (int i = 0; i < busy_delay && !abort; i++) begin
          @(negedge clk);
          if (!cpu_resetn) abort = 1;
          else begin
            chk("rd_en_hold", rd_en_out, 1);
            chk("addr_hold_req", rd_addr_out, a);
          end
        end
        if (!abort) begin
          busy_read = 1;
          @(negedge clk);
          if (!cpu_resetn) abort = 1;
          else chk("rd_en_drop", rd_en_out, 0);
          in_wait = 1;
          for (int i = 0; i < lat && !abort; i++) begin
            @(negedge clk);
            if (!cpu_resetn) abort = 1;
            else chk("addr_hold_wait", rd_addr_out, a);
          end
        end
        if (!abort) begin
          rd_data_in = make_word(a);
          ddr_read_ready = 1;
          @(negedge clk);
        end
        busy_read = 0;
        ddr_read_ready = 0;
        in_wait = 0;
      end
    end
  end

  // Compare process: every accepted pixel, held pixel and seq_done against the model.
  initial begin : compare
    int exp_idx;
    bit hold_v, exp_seq, hold_s, hold_e;
    logic [23:0] hold_d;
    exp_idx = 0; hold_v = 0; exp_seq = 0; hold_s = 0; hold_e = 0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (!cpu_resetn) begin
        exp_idx = 0; hold_v = 0; exp_seq = 0;
      end else begin
        chk("seq_done", seq_done, exp_seq);
        if (seq_done) seq_pulses++;
        exp_seq = 0;
        if (hold_v) begin
          chk("hold_valid", pix_valid, 1);
          chk("hold_data", pix_data, hold_d);
          chk("hold_sof", pix_sof, hold_s);
          chk("hold_eof", pix_eof, hold_e);
        end
        if (pix_valid && pix_ready) begin
          chk("pix_data", pix_data, exp_pix(exp_idx));
          chk("pix_sof", pix_sof, (exp_idx % NP) == 0);
          chk("pix_eof", pix_eof, (exp_idx % NP) == NP-1);
          if ((exp_idx % NP) == NP-1 && exp_frame(exp_idx) == NF-1) exp_seq = 1;
          acc_data.push_back(pix_data);
          acc_sof.push_back(pix_sof);
          acc_eof.push_back(pix_eof);
          acc_count++;
          exp_idx++;
          hold_v = 0;
        end else if (pix_valid) begin
          hold_v = 1; hold_d = pix_data; hold_s = pix_sof; hold_e = pix_eof;
        end else begin
          hold_v = 0;
        end
      end
    end
  end

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget && acc_count < n; i++) @(negedge clk);
    chk("acc_reached", acc_count >= n, 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en_out, 0);
    chk({tag, "_rd_addr"}, rd_addr_out, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_sof"}, pix_sof, 0);
    chk({tag, "_pix_eof"}, pix_eof, 0);
    chk({tag, "_seq_done"}, seq_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_resetn = 0; enable = 0; end_of_write = 0; pix_ready = 1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1 cpu_resetn = 1;

    // Stray data pulse while idle must be ignored.
    @(posedge clk); #1 ddr_read_ready = 1; rd_data_in = make_word(7);
    @(posedge clk); #1 ddr_read_ready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready_valid", pix_valid, 0);
      chk("idle_ready_rd_en", rd_en_out, 0);
    end

    busy_delay = 5; lat = 3;
    @(posedge clk); #1 enable = 1; end_of_write = 1;
    wait_acc(2, 500);
    @(posedge clk); #1 pix_ready = 0;
    repeat (10) @(posedge clk);
    #1 pix_ready = 1;
    wait_acc(2*NP, 3000);
    repeat (5) @(negedge clk);
    chk("seq_pulses_1", seq_pulses, 1);
    chk("lit_p0_data", acc_data[0], 24'h000001);
    chk("lit_p0_sof", acc_sof[0], 1);
    chk("lit_p1_sof", acc_sof[1], 0);
    chk("lit_p4_data", acc_data[4], 24'h000005);
    chk("lit_p12_data", acc_data[12], 24'h00000D);
    chk("lit_p12_eof", acc_eof[12], 1);
    chk("lit_p13_data", acc_data[13], 24'h000010);
    chk("lit_p13_sof", acc_sof[13], 1);
    chk("lit_p25_data", acc_data[25], 24'h00001C);
    chk("lit_p25_eof", acc_eof[25], 1);

    busy_delay = 0; lat = 2;
    @(posedge clk); #1 pix_ready = 0;
`ifndef LOOP_PLAYBACK_EN
    repeat (20) @(negedge clk);
    chk("done_no_req", req_count, MAXA*NF);
    chk("done_rd_en", rd_en_out, 0);
    @(posedge clk); #1 enable = 0;
    repeat (3) @(posedge clk);
    #1 enable = 1;
`endif
    repeat (80) @(negedge clk);
    chk("bp_req_count", req_count, word_idx(acc_count) + 1 + DEPTH);
    chk("bp_rd_en", rd_en_out, 0);
    @(posedge clk); #1 pix_ready = 1;
    wait_acc(4*NP, 3000);
    repeat (5) @(negedge clk);
    chk("seq_pulses_2", seq_pulses, 2);

    lat = 30;
    @(posedge clk); #1 enable = 0;
    repeat (3) @(posedge clk);
    #1 enable = 1;
    for (int i = 0; i < 500 && !in_wait; i++) @(negedge clk);
    chk("wait_data_reached", in_wait, 1);
    @(posedge clk); #1 cpu_resetn = 0; enable = 0;
    repeat (2) begin
      @(negedge clk);
      chk_outputs_zero("midrst");
    end
    @(posedge clk); #1 cpu_resetn = 1; req_idx = 0; lat = 2; base = acc_count;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_empty", pix_valid, 0);
    end
    @(posedge clk); #1 enable = 1;
    wait_acc(base + NP, 1500);
    chk("post_rst_p0_data", acc_data[base], 24'h000001);
    chk("post_rst_p0_sof", acc_sof[base], 1);
    chk("post_rst_p12_eof", acc_eof[base+12], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
